// File: rtl/alu_seq_if.sv
// Request/result bundle for the alu_seq execute unit.
// The master drives operands and IN_VALID; the slave returns IN_READY, the result and the flags.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] IM;
    logic [1:0]       SEL;
    logic [2:0]       OP;
    logic             IN_VALID;
    logic             IN_READY;
    logic             OUT_VALID;
    logic [WIDTH-1:0] STOREDATA;
    logic             Z_FLAG;
    logic             C_FLAG;

    modport master (
        output X, Y, IM, SEL, OP, IN_VALID,
        input  IN_READY, OUT_VALID, STOREDATA, Z_FLAG, C_FLAG
    );

    modport slave (
        input  X, Y, IM, SEL, OP, IN_VALID,
        output IN_READY, OUT_VALID, STOREDATA, Z_FLAG, C_FLAG
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic, bit-serial SHL, optional shift-add MUL.
// Define ALU_MUL_EN to build the multiplier; otherwise OP 111 passes operand A through.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int NW = CW + 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_ADC = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH:0]   ext;
    logic             alu_c;
    logic             accept;
    logic             last;
    op_e              op_in;

`ifdef ALU_MUL_EN
    op_e                op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_sum;
`endif

    assign op_in         = op_e'(bus.OP);
    assign bus.IN_READY  = (state_q == IDLE) && !RST;
    assign accept        = bus.IN_VALID && bus.IN_READY;
    assign last          = (cnt_q == NW'(1));
    assign sh_next       = {sh_q[WIDTH-2:0], 1'b0};

    assign bus.OUT_VALID = out_valid_q;
    assign bus.STOREDATA = result_q;
    assign bus.Z_FLAG    = z_q;
    assign bus.C_FLAG    = c_q;

    always_comb begin
        case (bus.SEL)
            2'b00:   b_op = bus.Y;
            2'b01:   b_op = bus.IM;
            2'b10:   b_op = '0;
            default: b_op = '1;
        endcase
    end

    // Arithmetic runs one bit wider so the top bit is the carry, or the borrow for SUB.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        ext     = '0;
        alu_res = bus.X;
        alu_c   = 1'b0;
        case (op_in)
            OP_ADD: begin
                ext     = {1'b0, bus.X} + {1'b0, b_op};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_ADC: begin
                ext     = {1'b0, bus.X} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                ext     = {1'b0, bus.X} - {1'b0, b_op};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND:  alu_res = bus.X & b_op;
            OP_OR:   alu_res = bus.X | b_op;
            OP_XOR:  alu_res = bus.X ^ b_op;
            default: alu_res = bus.X;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        z_d         = z_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
        op_d        = op_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        acc_sum     = acc_q + (sh_q[0] ? mcand_q : '0);
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_in == OP_SHL && b_op[CW-1:0] != '0) begin
                        state_d = BUSY;
                        sh_d    = bus.X;
                        cnt_d   = {1'b0, b_op[CW-1:0]};
`ifdef ALU_MUL_EN
                        op_d    = OP_SHL;
`endif
                    end
`ifdef ALU_MUL_EN
                    else if (op_in == OP_MUL) begin
                        state_d = BUSY;
                        op_d    = OP_MUL;
                        sh_d    = b_op;
                        mcand_d = {{WIDTH{1'b0}}, bus.X};
                        acc_d   = '0;
                        cnt_d   = NW'(WIDTH);
                    end
`endif
                    else begin
                        result_d    = alu_res;
                        z_d         = (alu_res == '0);
                        c_d         = alu_c;
                        out_valid_d = 1'b1;
                    end
                end
            end

            BUSY: begin
                cnt_d = cnt_q - NW'(1);
`ifdef ALU_MUL_EN
                // Multiplier bits are consumed LSB first from sh_q while the multiplicand walks left.
                if (op_q == OP_MUL) begin
                    acc_d   = acc_sum;
                    mcand_d = mcand_q << 1;
                    sh_d    = sh_q >> 1;
                    if (last) begin
                        result_d = acc_sum[WIDTH-1:0];
                        z_d      = (acc_sum[WIDTH-1:0] == '0);
                        c_d      = |acc_sum[2*WIDTH-1:WIDTH];
                    end
                end else
`endif
                begin
                    sh_d = sh_next;
                    if (last) begin
                        result_d = sh_next;
                        z_d      = (sh_next == '0);
                        c_d      = sh_q[WIDTH-1];
                    end
                end
                if (last) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            op_q        <= OP_ADD;
            acc_q       <= '0;
            mcand_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            op_q        <= op_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4: table of single-cycle vectors, then SHL/MUL and reset sequences.
// Expectations for OP 111 follow whether ALU_MUL_EN is defined for the build.
module tb_alu_seq;
    localparam int WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef struct {
        string      name;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] im;
        logic [1:0] sel;
        logic [2:0] op;
        logic [3:0] d;
        logic       z;
        logic       c;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[12];

    alu_seq_if #(.WIDTH(WIDTH)) bus_if ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic [3:0] im,
                         input logic [1:0] sel, input logic [2:0] op);
        bus_if.X   = x;
        bus_if.Y   = y;
        bus_if.IM  = im;
        bus_if.SEL = sel;
        bus_if.OP  = op;
    endtask

    // Accept one request, then swap the inputs to ADD 1+1 with IN_VALID still high.
    // A correct DUT ignores them while busy and takes them right after completing.
    task automatic run_multi(input string tag, input logic [3:0] x, input logic [3:0] y,
                             input logic [3:0] im, input logic [1:0] sel, input logic [2:0] op,
                             input int exp_edges, input logic [3:0] exp_d,
                             input logic exp_z, input logic exp_c);
        int edges;
        int lows;
        @(negedge CLK);
        drive(x, y, im, sel, op);
        bus_if.IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        edges = 0;
        lows  = 0;
        if (!bus_if.OUT_VALID && !bus_if.IN_READY) lows++;
        @(negedge CLK);
        drive(4'b0001, 4'b0001, 4'b0000, 2'b00, OP_ADD);
        while (!bus_if.OUT_VALID && edges < 20) begin
            @(posedge CLK);
            #1;
            edges++;
            if (!bus_if.OUT_VALID && !bus_if.IN_READY) lows++;
        end
        check({tag, " out_valid_seen"}, bus_if.OUT_VALID, 1);
        check({tag, " edges_to_valid"}, edges, exp_edges);
        check({tag, " ready_low_cycles"}, lows, exp_edges);
        check({tag, " data"}, bus_if.STOREDATA, exp_d);
        check({tag, " z"}, bus_if.Z_FLAG, exp_z);
        check({tag, " c"}, bus_if.C_FLAG, exp_c);
        check({tag, " ready_at_done"}, bus_if.IN_READY, 1);
        @(posedge CLK);
        #1;
        check({tag, " chained_add_valid"}, bus_if.OUT_VALID, 1);
        check({tag, " chained_add_data"}, bus_if.STOREDATA, 4'b0010);
        @(negedge CLK);
        bus_if.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, " valid_drops"}, bus_if.OUT_VALID, 0);
    endtask

    initial begin
        int ov_seen;

        vecs[0]  = '{"add_basic", 4'b0101, 4'b1010, 4'b0000, 2'b00, OP_ADD, 4'b1111, 1'b0, 1'b0};
        vecs[1]  = '{"xor_zero",  4'b0101, 4'b0101, 4'b0000, 2'b00, OP_XOR, 4'b0000, 1'b1, 1'b0};
        vecs[2]  = '{"add_carry", 4'b1000, 4'b0000, 4'b1000, 2'b01, OP_ADD, 4'b0000, 1'b1, 1'b1};
        vecs[3]  = '{"adc_c1",    4'b0001, 4'b0001, 4'b0000, 2'b00, OP_ADC, 4'b0011, 1'b0, 1'b0};
        vecs[4]  = '{"sub_borrow",4'b0011, 4'b0101, 4'b0000, 2'b00, OP_SUB, 4'b1110, 1'b0, 1'b1};
        vecs[5]  = '{"sub_equal", 4'b0101, 4'b0101, 4'b0000, 2'b00, OP_SUB, 4'b0000, 1'b1, 1'b0};
        vecs[6]  = '{"and_ones",  4'b1100, 4'b0000, 4'b0000, 2'b11, OP_AND, 4'b1100, 1'b0, 1'b0};
        vecs[7]  = '{"or_zeros",  4'b0000, 4'b1111, 4'b1111, 2'b10, OP_OR,  4'b0000, 1'b1, 1'b0};
        vecs[8]  = '{"add_ones",  4'b1111, 4'b0000, 4'b0000, 2'b11, OP_ADD, 4'b1110, 1'b0, 1'b1};
        vecs[9]  = '{"adc_zero_b",4'b0000, 4'b1111, 4'b0000, 2'b10, OP_ADC, 4'b0001, 1'b0, 1'b0};
        vecs[10] = '{"shl_by0",   4'b1011, 4'b0000, 4'b0100, 2'b01, OP_SHL, 4'b1011, 1'b0, 1'b0};
        vecs[11] = '{"adc_c0",    4'b0111, 4'b0001, 4'b0000, 2'b00, OP_ADC, 4'b1000, 1'b0, 1'b0};

        RST = 1'b1;
        bus_if.IN_VALID = 1'b0;
        drive('0, '0, '0, 2'b00, OP_ADD);
        #12;
        check("reset in_ready", bus_if.IN_READY, 0);
        check("reset out_valid", bus_if.OUT_VALID, 0);
        check("reset data", bus_if.STOREDATA, 0);
        check("reset z", bus_if.Z_FLAG, 0);
        check("reset c", bus_if.C_FLAG, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("ready after reset", bus_if.IN_READY, 1);

        // Back-to-back single-cycle requests, IN_VALID held high throughout.
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            drive(vecs[i].x, vecs[i].y, vecs[i].im, vecs[i].sel, vecs[i].op);
            bus_if.IN_VALID = 1'b1;
            @(posedge CLK);
            #1;
            check({vecs[i].name, " valid"}, bus_if.OUT_VALID, 1);
            check({vecs[i].name, " data"}, bus_if.STOREDATA, vecs[i].d);
            check({vecs[i].name, " z"}, bus_if.Z_FLAG, vecs[i].z);
            check({vecs[i].name, " c"}, bus_if.C_FLAG, vecs[i].c);
            check({vecs[i].name, " ready"}, bus_if.IN_READY, 1);
        end
        @(negedge CLK);
        bus_if.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        check("idle valid low", bus_if.OUT_VALID, 0);
        check("idle data held", bus_if.STOREDATA, 4'b1000);

        run_multi("shl3", 4'b0111, 4'b0000, 4'b0011, 2'b01, OP_SHL, 3, 4'b1000, 1'b0, 1'b1);
        run_multi("shl1", 4'b1001, 4'b0001, 4'b0000, 2'b00, OP_SHL, 1, 4'b0010, 1'b0, 1'b1);
        run_multi("shl3_z", 4'b0001, 4'b0000, 4'b0000, 2'b11, OP_SHL, 3, 4'b1000, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
        run_multi("mul", 4'b0110, 4'b0011, 4'b0000, 2'b00, OP_MUL, 4, 4'b0010, 1'b0, 1'b1);
        run_multi("mul_small", 4'b0011, 4'b0101, 4'b0000, 2'b00, OP_MUL, 4, 4'b1111, 1'b0, 1'b0);
`else
        run_multi("mul", 4'b0110, 4'b0011, 4'b0000, 2'b00, OP_MUL, 0, 4'b0110, 1'b0, 1'b0);
`endif

        // Reset in the second busy cycle of a multi-cycle op discards it.
        @(negedge CLK);
`ifdef ALU_MUL_EN
        drive(4'b0110, 4'b0011, 4'b0000, 2'b00, OP_MUL);
`else
        drive(4'b0111, 4'b0000, 4'b0011, 2'b01, OP_SHL);
`endif
        bus_if.IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus_if.IN_VALID = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("midop reset data", bus_if.STOREDATA, 0);
        check("midop reset z", bus_if.Z_FLAG, 0);
        check("midop reset c", bus_if.C_FLAG, 0);
        check("midop reset valid", bus_if.OUT_VALID, 0);
        check("midop reset ready", bus_if.IN_READY, 0);
        ov_seen = 0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            if (bus_if.OUT_VALID) ov_seen++;
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post reset ready", bus_if.IN_READY, 1);
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (bus_if.OUT_VALID) ov_seen++;
        end
        check("no valid after abort", ov_seen, 0);
        @(negedge CLK);
        drive(4'b0001, 4'b0001, 4'b0000, 2'b00, OP_ADD);
        bus_if.IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        check("post reset add valid", bus_if.OUT_VALID, 1);
        check("post reset add data", bus_if.STOREDATA, 4'b0010);
        check("post reset add c", bus_if.C_FLAG, 0);
        @(negedge CLK);
        bus_if.IN_VALID = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised successor to the TTM4 4-bit ALU, used as the execute unit for the next emulator core.
- Datapath width is generic; opcode select is binary instead of one-hot active-low enables.
- Uses a valid/ready input handshake and registered result/flags.
- Adds multi-cycle operations: a shift-left executed one bit per cycle, and an optional shift-add multiply.

Parameters:
WIDTH, 4, datapath width in bits; must be a power of two and at least 4.

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  asynchronous, active-high reset
X  in  WIDTH  operand A
Y  in  WIDTH  operand B source 0
IM  in  WIDTH  operand B source 1 (immediate)
SEL  in  2  operand B select: 00=Y, 01=IM, 10=all zeros, 11=all ones
OP  in  3  opcode: 000 ADD, 001 ADC, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SHL, 111 MUL
IN_VALID  in  1  request valid
IN_READY  out  1  block can accept a request
OUT_VALID  out  1  one-cycle pulse: STOREDATA and flags updated
STOREDATA  out  WIDTH  registered result
Z_FLAG  out  1  registered zero flag
C_FLAG  out  1  registered carry/borrow/overflow flag

Behaviour:
- Reset (asynchronous, any state):
  - STOREDATA=0, Z_FLAG=0, C_FLAG=0, OUT_VALID=0, state=IDLE.
  - IN_READY=0 while RST=1.
  - Any in-flight operation is discarded with no OUT_VALID.
- States: IDLE, BUSY. IN_READY = (state==IDLE) && !RST.
- Accept: request accepted at a rising edge where IN_VALID && IN_READY. X, B, OP and the shift count are latched at that edge. Input changes during BUSY are ignored.
- Single-cycle ops (ADD, ADC, SUB, AND, OR, XOR, and SHL with count 0):
  - Result and flags are written at the accept edge; OUT_VALID=1 for the following cycle.
  - State stays IDLE, so back-to-back accepts are allowed at one per cycle.
- Arithmetic, computed at WIDTH+1 bits:
  - ADD: C = carry out.
  - ADC: adds the C_FLAG value present at the accept edge, which is the result of the previous op even when back-to-back.
  - SUB: A-B, C = borrow (1 when A<B unsigned).
  - AND/OR/XOR: C=0.
  - Z = (STOREDATA==0) for every op.
- SHL:
  - Count n = B[log2(WIDTH)-1:0].
  - n=0: result A, C=0, single-cycle.
  - n>0: go BUSY; shift one bit per edge. C = last bit shifted out of the MSB.
  - Result committed at the n-th BUSY edge, then state returns to IDLE. Latency n cycles from accept to OUT_VALID.
- MUL (see Optional Feature):
  - Shift-add over WIDTH bits of B, one bit per BUSY edge, with a 2*WIDTH accumulator.
  - Commits after WIDTH BUSY edges. STOREDATA = low WIDTH bits; C = 1 if the high half is nonzero.
- OUT_VALID is high for exactly one cycle per accepted request and is never held. There is no output back-pressure.
- Completion edge: IN_READY rises in the same cycle OUT_VALID is high, so a new request can be accepted at the next edge.
- Flags and STOREDATA hold their values between operations.

Optional Feature:
ALU_MUL_EN
- Defined: OP 111 performs the multi-cycle MUL described above.
- Undefined: OP 111 is a single-cycle pass-through: STOREDATA=A, C=0, Z per result. No multiplier or accumulator logic is synthesised.

Test Plan:
1. WIDTH=4, ADD X=0101, Y=1010, SEL=00 -> next cycle OUT_VALID=1, STOREDATA=1111, Z=0, C=0. Then XOR X=0101, Y=0101 -> 0000, Z=1, C=0.
2. ADD X=1000, IM=1000, SEL=01 -> 0000, Z=1, C=1. Immediately followed by ADC X=0001, Y=0001 -> 0011, C=0. Two consecutive OUT_VALID pulses.
3. SUB X=0011, Y=0101 -> STOREDATA=1110, C=1, Z=0. SUB X=0101, Y=0101 -> 0000, C=0, Z=1.
4. SHL X=0111, IM=0011, SEL=01 -> IN_READY low 3 cycles; OUT_VALID 3 cycles after accept; STOREDATA=1000, C=1. IN_VALID held high during BUSY causes no extra accept.
5. MUL X=0110, Y=0011:
   - ALU_MUL_EN defined -> latency 4, STOREDATA=0010, C=1.
   - ALU_MUL_EN undefined -> latency 1, STOREDATA=0110, C=0.
6. Assert RST during the second BUSY cycle of MUL -> outputs clear immediately, no OUT_VALID pulse; after release IN_READY=1 and ADD X=0001, Y=0001 returns 0010.
